sliding_window_buf: RTL

Parametrised WIN×WIN sliding-window buffer for the median-filter path. It takes one vertical column of WIN pixels per accepted beat from the line buffers and produces one registered window per pixel of the line, centred on that pixel. Every window entry carries a valid flag, so positions outside the line are marked as padding (flag 0). Line start and end markers drive the border fill and flush. A ready/valid handshake on both sides lets the block absorb downstream stalls.

---
 rtl/sliding_window_buf.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sliding_window_buf.sv
// WIN x WIN sliding-window buffer. It takes one column per beat and emits one window
// centred on each pixel of the line. Positions outside the line carry a zero flag.
module sliding_window_buf #(
    parameter int WIN   = 11,
    parameter int DW    = 9,
    parameter int MAX_W = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sol,
    input  logic                      in_eol,
    input  logic [WIN*DW-1:0]         in_col,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIN*WIN*(DW+1)-1:0] win_out,
    output logic [$clog2(MAX_W)-1:0]  out_x,
    output logic                      out_sol,
    output logic                      out_eol,
    output logic                      err
);
    // state | meaning
    // IDLE  | between lines, waiting for a column flagged sol
    // RUN   | accepting the columns of the current line
    // FLUSH | shifting in padding columns to emit the last HALF windows

    localparam int HALF = (WIN - 1) / 2;
    localparam int XW   = $clog2(MAX_W);
    localparam int FW   = $clog2(HALF + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                           state_q;
    logic [FW-1:0]                    fcnt_q;
    logic [XW-1:0]                    xc_q, xc_d, out_x_q;
    logic                             out_valid_q, out_eol_q, err_q;
    logic [WIN-1:0][WIN-1:0][DW:0]    col_q, col_d;

    logic can_move, accept, take, flush_step, shift, border_clr, new_flag;

    assign can_move   = !out_valid_q || out_ready;
    assign in_ready   = (state_q != FLUSH) && can_move;
    assign accept     = in_valid && in_ready;
    // In IDLE only a sol column may start a line; anything else is dropped.
    assign take       = accept && (in_sol || state_q == RUN);
    assign flush_step = (state_q == FLUSH) && can_move;
    assign shift      = take || flush_step;
    assign border_clr = take && in_sol;

    always_comb begin
        col_d = col_q;
        if (shift) begin
            for (int c = 1; c < WIN; c++)
                col_d[c] = border_clr ? '0 : col_q[c-1];
            for (int r = 0; r < WIN; r++)
                col_d[0][r] = take ? {1'b1, in_col[r*DW +: DW]} : '0;
        end
    end

    assign new_flag = col_d[HALF][0][DW];

    // The centre advances whenever the column leaving the centre was a real pixel.
    // That also holds across input gaps, where the window has already been consumed.
    always_comb begin
        xc_d = xc_q;
        if (border_clr)
            xc_d = '0;
        else if (shift && col_q[HALF][0][DW])
            xc_d = xc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            xc_q        <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_eol_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            col_q <= col_d;
            xc_q  <= xc_d;
            if (shift) begin
                out_valid_q <= new_flag;
                out_x_q     <= new_flag ? xc_d : '0;
                out_eol_q   <= flush_step && (fcnt_q == FW'(1));
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept && (state_q == IDLE) && !in_sol)
                err_q <= 1'b1;
            if (accept && (state_q == RUN) && in_sol)
                err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept && in_sol) begin
                        if (in_eol) begin
                            state_q <= FLUSH;
                            fcnt_q  <= FW'(HALF);
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept && in_eol) begin
                        state_q <= FLUSH;
                        fcnt_q  <= FW'(HALF);
                    end
                end
                FLUSH: begin
                    if (flush_step) begin
                        fcnt_q <= fcnt_q - 1'b1;
                        if (fcnt_q == FW'(1))
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar gr = 0; gr < WIN; gr++) begin : g_row
        for (genvar gc = 0; gc < WIN; gc++) begin : g_col
            assign win_out[((gr*WIN+gc)*(DW+1)) +: DW+1] = col_q[gc][gr];
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_sol   = out_valid_q && (out_x_q == '0);
    assign out_eol   = out_eol_q;
    assign err       = err_q;

endmodule
